mont_arbiter: RTL

MONT_ARBITER -- requirements
Module: mont_arbiter

---
 rtl/rsa_pkg.sv | 16 +
 rtl/mont_watchdog.sv | 30 +++
 rtl/mont_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the Montgomery arbiter slice.
// Holds operand width, FSM state encoding and port index type.
package rsa_pkg;

  localparam int MONT_WIDTH = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef logic port_t;

endpackage

// File: rtl/mont_watchdog.sv
// Counts cycles while enabled; flags the last permitted cycle.
// Ports: i_clk, i_rst, i_clr (zero count), i_en (count), o_expired.
module mont_watchdog #(
  parameter int TIMEOUT = 512
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int LW = $clog2(TIMEOUT + 1);
  localparam int CW = (LW > 10) ? LW : 10;

  logic [CW-1:0] cnt;

  // expired marks the TIMEOUT-th enabled cycle, so the
  // owner leaves its wait state exactly TIMEOUT cycles in.
  assign o_expired = i_en && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt <= '0;
    end else if (i_en && !o_expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mont_arbiter.sv
// Round-robin arbiter sharing one external Montgomery unit.
// Ports: two req/ack/done/result requesters, mont_* unit side, o_err.
module mont_arbiter
  import rsa_pkg::*;
#(
  parameter int WIDTH   = MONT_WIDTH,
  parameter int TIMEOUT = 512
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  input  logic [WIDTH-1:0] i_n,
  output logic             o_ack0,
  output logic             o_ack1,
  output logic             o_done0,
  output logic             o_done1,
  output logic [WIDTH-1:0] o_result0,
  output logic [WIDTH-1:0] o_result1,
  output logic             o_err,
  output logic             o_mont_start,
  output logic [WIDTH-1:0] o_mont_a,
  output logic [WIDTH-1:0] o_mont_b,
  output logic [WIDTH-1:0] o_mont_n,
  input  logic [WIDTH-1:0] i_mont_m,
  input  logic             i_mont_finished
);

  state_t state;
  state_t state_n;
  port_t  lock;
  port_t  ptr;
  port_t  grant;
  logic   any_req;
  logic   wd_exp;
  logic   in_wait;

  assign any_req = i_req0 || i_req1;
  assign in_wait = (state == S_WAIT);
  // Pointer only breaks ties; a lone requester always wins.
  assign grant   = (i_req0 && i_req1) ? ptr : i_req1;

  mont_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (!in_wait),
    .i_en     (in_wait),
    .o_expired(wd_exp)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (any_req) state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT:  if (i_mont_finished || wd_exp) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock      <= 1'b0;
      ptr       <= 1'b0;
      o_mont_a  <= '0;
      o_mont_b  <= '0;
      o_mont_n  <= '0;
      o_result0 <= '0;
      o_result1 <= '0;
      o_err     <= 1'b0;
    end else begin
      if (state == S_IDLE && any_req) begin
        lock     <= grant;
        o_mont_a <= grant ? i_a1 : i_a0;
        o_mont_b <= grant ? i_b1 : i_b0;
        o_mont_n <= i_n;
      end
      // finished takes priority over a same-cycle timeout.
      if (in_wait && i_mont_finished) begin
        if (lock) o_result1 <= i_mont_m;
        else      o_result0 <= i_mont_m;
      end else if (in_wait && wd_exp) begin
        if (lock) o_result1 <= '0;
        else      o_result0 <= '0;
        o_err <= 1'b1;
      end
      if (state == S_DONE) begin
        ptr <= ~lock;
      end
    end
  end

  assign o_mont_start = (state == S_ISSUE);
  assign o_ack0       = (state == S_ISSUE) && !lock;
  assign o_ack1       = (state == S_ISSUE) &&  lock;
  assign o_done0      = (state == S_DONE)  && !lock;
  assign o_done1      = (state == S_DONE)  &&  lock;

endmodule
